// File: rtl/led_pkg.sv
// led_pkg: shared constants, FSM states and segment decode for the LED display controller
package led_pkg;
    localparam int NUM_DIGITS  = 8;
    localparam int BCD_DIGITS  = 10;
    localparam int CONV_CYCLES = 32;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/led_display_ctrl_if.sv
// led_display_ctrl_if: CPU-side request/status bundle of the LED display controller
interface led_display_ctrl_if;
    logic        value_valid;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        overflow;

    modport master (output value_valid, value, input busy, done, overflow);
    modport slave (input value_valid, value, output busy, done, overflow);
endinterface

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: 32-cycle shift-add-3 binary to 10-digit BCD converter
module bcd_dabble_seq
    import led_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);
    state_t      state;
    logic [4:0]  cnt;
    logic [71:0] sr;
    logic [39:0] adj;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        assign adj[4*i +: 4] = sr[32+4*i +: 4] >= 4'd5 ? sr[32+4*i +: 4] + 4'd3 : sr[32+4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sr    <= {40'd0, din};
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CONV;
                end
                CONV: begin
                    sr  <= {adj, sr[31:0]} << 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(CONV_CYCLES - 1)) begin
                        done  <= 1'b1;
                        state <= COMMIT;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bcd = sr[71:32];
endmodule

// File: rtl/led_display_ctrl.sv
// led_display_ctrl: binary-to-BCD display sequencer with single-entry pending request and digit scan
module led_display_ctrl
    import led_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    led_display_ctrl_if.slave     bus,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    logic          conv_busy;
    logic          conv_done;
    logic          start;
    logic          pend_full;
    logic [31:0]   pend;
    logic [31:0]   display;
    logic [39:0]   bcd;
    logic          overflow;
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [31:0]   upper;
    logic [3:0]    digit;

    // a full pending slot wins over a fresh request so request order is preserved
    assign start = !conv_busy && (bus.value_valid || pend_full);

    bcd_dabble_seq u_conv (
        .clk,
        .rst,
        .start,
        .din (pend_full ? pend : bus.value),
        .busy(conv_busy),
        .done(conv_done),
        .bcd
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend      <= '0;
            display   <= '0;
            overflow  <= 1'b0;
            presc     <= '0;
            idx       <= '0;
        end else begin
            if (bus.value_valid && (conv_busy || pend_full)) begin
                pend      <= bus.value;
                pend_full <= 1'b1;
            end else if (start) begin
                pend_full <= 1'b0;
            end
            if (conv_done) begin
                display  <= bcd[31:0];
                overflow <= |bcd[39:32];
            end
            presc <= presc == PW'(SCAN_DIV - 1) ? '0 : presc + 1'b1;
            if (presc == PW'(SCAN_DIV - 1)) idx <= idx + 3'd1;
        end
    end

    assign upper = display >> {idx, 2'b00};
    assign digit = display[{idx, 2'b00} +: 4];
    assign an    = ~(8'b1 << idx);
    assign seg   = BLANK_LEADING != 0 && idx != 3'd0 && upper == '0 ? SEG_BLANK : seg_decode(digit);

    assign bus.busy     = conv_busy;
    assign bus.done     = conv_done;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_led_display_ctrl.sv
// tb_led_display_ctrl: directed and random requests checked against a decimal-arithmetic display model
module tb_led_display_ctrl;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] an;
    logic [7:0] seg;
    int         checks = 0;
    int         errors = 0;

    // model: phase 0 = idle, 1..33 = cycles of an accepted conversion (33 = commit)
    int              phase = 0;
    bit              pfull = 0;
    longint unsigned cur   = 0;
    longint unsigned pend  = 0;
    longint unsigned disp  = 0;
    bit              ovf   = 0;
    int              t     = 0;

    led_display_ctrl_if bus();

    led_display_ctrl #(.SCAN_DIV(DIV), .BLANK_LEADING(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .an (an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input longint unsigned v, input int i);
        logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        longint unsigned q = v / longint'(10 ** i);
        if (i > 0 && q == 0) return 8'hFF;
        return codes[int'(q % 10)];
    endfunction

    task automatic compare();
        int         i = (t / DIV) % 8;
        logic [7:0] one = 8'd1;
        check("busy", {31'd0, bus.busy}, {31'd0, phase != 0});
        check("done", {31'd0, bus.done}, {31'd0, phase == 33});
        check("overflow", {31'd0, bus.overflow}, {31'd0, ovf});
        check("an", {24'd0, an}, {24'd0, 8'hFF ^ (one << i)});
        check("seg", {24'd0, seg}, {24'd0, exp_seg(disp, i)});
    endtask

    task automatic model(input bit r, input bit vv, input logic [31:0] v);
        bit acc;
        if (r) begin
            phase = 0; pfull = 0; disp = 0; ovf = 0; t = 0;
            return;
        end
        if (phase == 33) begin
            disp = cur % 100000000;
            ovf  = cur >= 100000000;
        end
        acc = phase == 0 && (vv || pfull);
        if (acc) cur = pfull ? pend : longint'(v);
        if (vv && (phase != 0 || pfull)) begin
            pend  = longint'(v);
            pfull = 1;
        end else if (acc) begin
            pfull = 0;
        end
        phase = acc ? 1 : (phase == 0 || phase == 33) ? 0 : phase + 1;
        t++;
    endtask

    task automatic step(input bit r, input bit vv, input logic [31:0] v);
        @(negedge clk);
        compare();
        rst             = r;
        bus.value_valid = vv;
        bus.value       = v;
        model(r, vv, v);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, $urandom);
    endtask

    task automatic req(input logic [31:0] v);
        step(0, 1, v);
    endtask

    initial begin
        bus.value_valid = 1'b0;
        bus.value       = '0;
        step(1, 0, 0);
        step(1, 0, 0);
        idle(40);
        req(32'd12345678);     idle(80);
        req(32'hFFFFFFFF);     idle(80);
        req(32'd42);           idle(80);
        req(32'd0);            idle(80);
        req(32'd100); idle(5); req(32'd5); idle(3); req(32'd7); idle(120);
        req(32'd999); idle(9); step(1, 0, 0); idle(50);
        req(32'd3);            idle(80);
        req(32'd100000000);    idle(80);
        req(32'd99999999);     idle(80);
        for (int k = 0; k < 2000; k++) begin
            logic [31:0] v = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 99999);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, v);
        end
        idle(80);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
